// File: rtl/m_mem_arbiter.sv
// Per-cycle arbiter sharing one single-port synchronous memory between the IF (fetch) and MEM (lw/sw) ports.
// Optional starvation guard for the IF port is enabled by defining STARVE_GUARD_EN.
module m_mem_arbiter #(
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              w_clk,
    input  logic              w_rst,
    input  logic              w_i_req,
    input  logic [ADDR_W-1:0] w_i_addr,
    output logic              w_i_gnt,
    output logic              r_i_vld,
    output logic [DATA_W-1:0] w_i_rdata,
    input  logic              w_d_req,
    input  logic              w_d_we,
    input  logic [ADDR_W-1:0] w_d_addr,
    input  logic [DATA_W-1:0] w_d_wdata,
    output logic              w_d_gnt,
    output logic              r_d_vld,
    output logic [DATA_W-1:0] w_d_rdata,
    output logic [ADDR_W-1:0] w_m_addr,
    output logic              w_m_we,
    output logic [DATA_W-1:0] w_m_din,
    input  logic [DATA_W-1:0] w_m_dout,
    output logic [15:0]       r_conf_cnt
);

`ifdef STARVE_GUARD_EN
    localparam bit GUARD_EN = 1'b1;
`else
    localparam bit GUARD_EN = 1'b0;
`endif
    localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);

    typedef enum logic {ARB, FORCE} mode_e;

    mode_e      r_mode, w_mode_nxt;
    logic [2:0] r_starve, w_starve_nxt;
    logic       r_i_vld_q, r_d_vld_q;
    logic       w_force_if;

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        w_i_gnt      = 1'b0;
        w_d_gnt      = 1'b0;
        w_force_if   = GUARD_EN && (r_mode == FORCE) && w_i_req;
        w_mode_nxt   = ARB;
        w_starve_nxt = '0;

        if (!w_rst) begin
            if (w_force_if)   w_i_gnt = 1'b1;
            else if (w_d_req) w_d_gnt = 1'b1;
            else if (w_i_req) w_i_gnt = 1'b1;
        end

        if (GUARD_EN) begin
            if (w_i_req && !w_i_gnt)
                w_starve_nxt = (r_starve >= STARVE_LIM) ? STARVE_LIM : r_starve + 3'd1;
            // FORCE always lasts one cycle: it either serves IF or IF has dropped its request.
            if (r_mode == ARB && w_starve_nxt == STARVE_LIM)
                w_mode_nxt = FORCE;
        end
    end

    always_comb begin
        w_m_addr = '0;
        w_m_we   = 1'b0;
        w_m_din  = '0;
        if (w_i_gnt) begin
            w_m_addr = w_i_addr;
        end else if (w_d_gnt) begin
            w_m_addr = w_d_addr;
            w_m_we   = w_d_we;
            w_m_din  = w_d_we ? w_d_wdata : '0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            r_mode     <= ARB;
            r_starve   <= '0;
            r_i_vld_q  <= 1'b0;
            r_d_vld_q  <= 1'b0;
            r_conf_cnt <= '0;
        end else begin
            r_mode     <= w_mode_nxt;
            r_starve   <= w_starve_nxt;
            r_i_vld_q  <= w_i_gnt;
            r_d_vld_q  <= w_d_gnt & ~w_d_we;
            if (w_i_req && w_d_req && r_conf_cnt != 16'hFFFF)
                r_conf_cnt <= r_conf_cnt + 16'd1;
        end
    end

    // NOTE: valids are masked by reset so an access granted just before reset never reports data.
    assign r_i_vld   = r_i_vld_q & ~w_rst;
    assign r_d_vld   = r_d_vld_q & ~w_rst;
    assign w_i_rdata = w_m_dout;
    assign w_d_rdata = w_m_dout;

endmodule

// File: tb/tb_m_mem_arbiter.sv
// Scoreboard bench for m_mem_arbiter: behavioural grant/memory model, decoupled read-data monitor.
module tb_m_mem_arbiter;
    localparam int ADDR_W     = 12;
    localparam int DATA_W     = 32;
    localparam int STARVE_MAX = 4;
`ifdef STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic w_clk = 1'b0;
    always #5 w_clk = ~w_clk;

    logic              w_rst = 1'b1;
    logic              w_i_req = 1'b0, w_d_req = 1'b0, w_d_we = 1'b0;
    logic [ADDR_W-1:0] w_i_addr = '0, w_d_addr = '0;
    logic [DATA_W-1:0] w_d_wdata = '0;
    logic              w_i_gnt, r_i_vld, w_d_gnt, r_d_vld, w_m_we;
    logic [DATA_W-1:0] w_i_rdata, w_d_rdata, w_m_din, w_m_dout;
    logic [ADDR_W-1:0] w_m_addr;
    logic [15:0]       r_conf_cnt;

    m_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)) dut (
        .w_clk(w_clk), .w_rst(w_rst),
        .w_i_req(w_i_req), .w_i_addr(w_i_addr), .w_i_gnt(w_i_gnt), .r_i_vld(r_i_vld), .w_i_rdata(w_i_rdata),
        .w_d_req(w_d_req), .w_d_we(w_d_we), .w_d_addr(w_d_addr), .w_d_wdata(w_d_wdata),
        .w_d_gnt(w_d_gnt), .r_d_vld(r_d_vld), .w_d_rdata(w_d_rdata),
        .w_m_addr(w_m_addr), .w_m_we(w_m_we), .w_m_din(w_m_din), .w_m_dout(w_m_dout),
        .r_conf_cnt(r_conf_cnt)
    );

    // Synchronous memory with 1-cycle read latency (environment, not the model).
    logic [DATA_W-1:0] cm_ram [0:4095];
    always @(posedge w_clk) begin
        w_m_dout <= cm_ram[w_m_addr];
        if (w_m_we) cm_ram[w_m_addr] = w_m_din;
    end

    // Reference model state.
    logic [DATA_W-1:0] ref_mem [0:4095];
    logic [DATA_W-1:0] iq[$], dq[$];
    logic [15:0]       conf_model = '0;
    int                run_len = 0;
    bit                last_ig = 1'b0, last_dg = 1'b0, obs_ig = 1'b0;
    int                n_chk = 0, n_pass = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // One cycle: predict and compare combinational outputs at negedge, update the model after the edge.
    task automatic step();
        bit                eig, edg, ewe;
        logic [ADDR_W-1:0] ea;
        logic [DATA_W-1:0] ed;
        @(negedge w_clk);
        eig = 1'b0;
        edg = 1'b0;
        if (!w_rst) begin
            if (w_i_req && w_d_req) begin
                if (GUARD && run_len >= STARVE_MAX) eig = 1'b1;
                else edg = 1'b1;
            end else if (w_i_req) eig = 1'b1;
            else if (w_d_req) edg = 1'b1;
        end
        ea  = eig ? w_i_addr : (edg ? w_d_addr : '0);
        ewe = edg && w_d_we;
        ed  = ewe ? w_d_wdata : '0;
        check("i_gnt", 64'(w_i_gnt), 64'(eig));
        check("d_gnt", 64'(w_d_gnt), 64'(edg));
        check("m_addr", 64'(w_m_addr), 64'(ea));
        check("m_we", 64'(w_m_we), 64'(ewe));
        check("m_din", 64'(w_m_din), 64'(ed));
        check("conf_cnt", 64'(r_conf_cnt), 64'(conf_model));
        obs_ig  = w_i_gnt;
        last_ig = eig;
        last_dg = edg;
        @(posedge w_clk);
        #1;
        if (w_rst) begin
            run_len    = 0;
            conf_model = '0;
            iq.delete();
            dq.delete();
        end else begin
            if (w_i_req && w_d_req && conf_model != 16'hFFFF) conf_model++;
            if (eig) iq.push_back(ref_mem[w_i_addr]);
            if (edg) begin
                if (w_d_we) ref_mem[w_d_addr] = w_d_wdata;
                else dq.push_back(ref_mem[w_d_addr]);
            end
            run_len = (w_i_req && !eig) ? run_len + 1 : 0;
        end
    endtask

    task automatic set_in(input bit ir, input int ia, input bit dr, input bit dw, input int da,
                          input logic [DATA_W-1:0] dd);
        w_i_req   = ir;
        w_i_addr  = ADDR_W'(ia);
        w_d_req   = dr;
        w_d_we    = dw;
        w_d_addr  = ADDR_W'(da);
        w_d_wdata = dd;
    endtask

    task automatic do_reset();
        w_rst = 1'b1;
        iq.delete();
        dq.delete();
        step();
        w_rst = 1'b0;
    endtask

    // Monitor: pops one expected word per cycle after each read grant.
    always @(negedge w_clk) begin
        if (w_rst) begin
            check("i_vld_in_rst", 64'(r_i_vld), 64'(0));
            check("d_vld_in_rst", 64'(r_d_vld), 64'(0));
        end else begin
            if (iq.size() > 0) begin
                check("i_vld", 64'(r_i_vld), 64'(1));
                check("i_rdata", 64'(w_i_rdata), 64'(iq.pop_front()));
            end else check("i_vld_idle", 64'(r_i_vld), 64'(0));
            if (dq.size() > 0) begin
                check("d_vld", 64'(r_d_vld), 64'(1));
                check("d_rdata", 64'(w_d_rdata), 64'(dq.pop_front()));
            end else check("d_vld_idle", 64'(r_d_vld), 64'(0));
        end
    end

    initial begin
        int if_wins;
        logic [DATA_W-1:0] v;
        for (int k = 0; k < 4096; k++) begin
            cm_ram[k]  = $urandom;
            ref_mem[k] = cm_ram[k];
        end
        set_in(0, 0, 0, 0, 0, '0);
        do_reset();

        // IF-only reads of 0..4.
        for (int a = 0; a < 5; a++) begin
            set_in(1, a, 0, 0, 0, '0);
            step();
        end
        set_in(0, 0, 0, 0, 0, '0);
        step();
        check("t1_conf", 64'(r_conf_cnt), 64'(0));

        // Simultaneous IF read and MEM write, then MEM read-back.
        do_reset();
        set_in(1, 3, 1, 1, 40, 32'h1234);
        step();
        set_in(1, 3, 0, 0, 0, '0);
        step();
        set_in(0, 0, 1, 0, 40, '0);
        step();
        set_in(0, 0, 0, 0, 0, '0);
        step();
        check("t2_conf", 64'(r_conf_cnt), 64'(1));
        check("t2_mem40", 64'(ref_mem[40]), 64'(32'h1234));

        // Sustained contention for 10 cycles.
        do_reset();
        if_wins = 0;
        set_in(1, 5, 1, 0, 6, '0);
        for (int c = 0; c < 10; c++) begin
            step();
            if (obs_ig) if_wins++;
        end
        set_in(0, 0, 0, 0, 0, '0);
        step();
        check("t3_if_wins", 64'(if_wins), GUARD ? 64'(2) : 64'(0));
        check("t3_conf", 64'(r_conf_cnt), 64'(10));

        // Reset the cycle after a MEM read grant; a write request is held through reset.
        do_reset();
        set_in(0, 0, 1, 0, 9, '0);
        step();
        set_in(0, 0, 1, 1, 9, 32'hDEAD_BEEF);
        do_reset();
        set_in(1, 2, 0, 0, 0, '0);
        step();
        set_in(0, 0, 0, 0, 0, '0);
        step();
        check("t4_conf", 64'(r_conf_cnt), 64'(0));

        // Write then read the same address on consecutive cycles.
        v = $urandom;
        set_in(0, 0, 1, 1, 100, v);
        step();
        set_in(1, 100, 0, 0, 0, '0);
        step();
        set_in(0, 0, 0, 0, 0, '0);
        step();

        // Random traffic; requests held until the model grants them.
        for (int c = 0; c < 400; c++) begin
            if (!w_i_req || last_ig) begin
                w_i_req  = ($urandom_range(0, 3) != 0);
                w_i_addr = ADDR_W'($urandom_range(0, 15));
            end
            if (!w_d_req || last_dg) begin
                w_d_req   = ($urandom_range(0, 3) != 0);
                w_d_we    = 1'($urandom_range(0, 1));
                w_d_addr  = ADDR_W'($urandom_range(0, 15));
                w_d_wdata = $urandom;
            end
            step();
        end
        set_in(0, 0, 0, 0, 0, '0);
        step();

        // Conflict counter saturation: 65534 cycles reach FFFE, 3 more must hold at FFFF.
        do_reset();
        set_in(1, 1, 1, 0, 2, '0);
        for (int c = 0; c < 65534; c++) step();
        check("t5_fffe", 64'(r_conf_cnt), 64'(16'hFFFE));
        for (int c = 0; c < 3; c++) step();
        check("t5_sat", 64'(r_conf_cnt), 64'(16'hFFFF));
        set_in(0, 0, 0, 0, 0, '0);
        step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
